// File: rtl/polytomsg_masked_pack_pkg.sv
// Shared constants and types for the masked poly-to-message packer.
// Holds the message geometry (coefficients, bytes), the message-bit index
// within a coefficient share, and the packer FSM state type.
package polytomsg_masked_pack_pkg;

  localparam int unsigned KYBER_N  = 256;
  localparam int unsigned N_BYTES  = KYBER_N / 8;
  localparam int unsigned COEFF_SZ = 16;
  localparam int unsigned QBITS2   = 13;
  localparam int unsigned MSG_BIT  = QBITS2 - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/polytomsg_bit_accum.sv
// One share's byte accumulator: inserts a message bit at position idx
// (LSB-first) and exposes the byte including that bit before it registers.
// Ports:
//   clk, rst    clock, async active-high reset
//   clr         synchronous clear (start of message)
//   ins         insert bit_in at idx this cycle
//   idx         bit position 0..7
//   bit_in      message-bit share
//   acc_o       registered partial byte
//   full_c      combinational byte with the current bit inserted
module polytomsg_bit_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ins,
  input  logic [2:0] idx,
  input  logic       bit_in,
  output logic [7:0] acc_o,
  output logic [7:0] full_c
);
  import polytomsg_masked_pack_pkg::*;

  logic [7:0] acc_q;
  logic [7:0] acc_d;

  // Byte as it looks with the current bit merged; the top loads this on bit 7.
  always_comb begin
    full_c      = acc_q;
    full_c[idx] = bit_in;
    acc_d       = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (ins) begin
      acc_d = (idx == 3'd7) ? 8'h00 : full_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/polytomsg_masked_pack.sv
// Packs the message-bit share of each Boolean-masked coefficient pair into
// byte-share pairs (m1, m2), LSB-first, 8 coefficients per byte. Shares stay
// separate end to end.
// Optional macro POLYTOMSG_PACK_REFRESH_EN adds input rnd[7:0]; each loaded
// byte pair is re-masked as (acc1^rnd, acc2^rnd).
// Ports:
//   clk, rst            clock, async active-high reset
//   start               begin a message (IDLE only)
//   in_valid/in_ready   coefficient share handshake (in_ready combinational)
//   x1, x2              coefficient shares
//   out_valid/out_ready byte share handshake
//   m1, m2              byte shares
//   byte_idx            index of the held byte
//   done                one-cycle pulse after the last byte is taken
//   rnd                 (macro only) fresh mask byte
module polytomsg_masked_pack #(
  parameter int unsigned KYBER_N  = polytomsg_masked_pack_pkg::KYBER_N,
  parameter int unsigned COEFF_SZ = polytomsg_masked_pack_pkg::COEFF_SZ,
  parameter int unsigned QBITS2   = polytomsg_masked_pack_pkg::QBITS2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [COEFF_SZ-1:0]          x1,
  input  logic [COEFF_SZ-1:0]          x2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   m1,
  output logic [7:0]                   m2,
  output logic [$clog2(KYBER_N/8)-1:0] byte_idx,
  output logic                         done
`ifdef POLYTOMSG_PACK_REFRESH_EN
  ,
  input  logic [7:0]                   rnd
`endif
);
  import polytomsg_masked_pack_pkg::*;

  localparam int unsigned BYTES = KYBER_N / 8;
  localparam int unsigned IDX_W = $clog2(BYTES);
  localparam int unsigned CNT_W = $clog2(KYBER_N + 1);
  localparam int unsigned MSG   = QBITS2 - 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         m1_q, m1_d, m2_q, m2_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic               done_q, done_d;

  logic               accept;
  logic               out_hs;
  logic               acc_clr;
  logic [7:0]         mask_c;
  logic [7:0]         acc1, acc2, full1_c, full2_c;

`ifdef POLYTOMSG_PACK_REFRESH_EN
  assign mask_c = rnd;
`else
  assign mask_c = 8'h00;
`endif

  // Bit 7 of a byte may only enter when the output register is free or
  // being emptied this cycle; bits 0..6 keep flowing under backpressure.
  assign in_ready = (state_q == ST_RUN) && (cnt_q < CNT_W'(KYBER_N)) &&
                    ((cnt_q[2:0] != 3'd7) || !out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign acc_clr  = (state_q == ST_IDLE) && start;

  polytomsg_bit_accum u_acc1 (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .ins    (accept),
    .idx    (cnt_q[2:0]),
    .bit_in (x1[MSG]),
    .acc_o  (acc1),
    .full_c (full1_c)
  );

  polytomsg_bit_accum u_acc2 (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .ins    (accept),
    .idx    (cnt_q[2:0]),
    .bit_in (x2[MSG]),
    .acc_o  (acc2),
    .full_c (full2_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    m1_d        = m1_q;
    m2_d        = m2_q;
    byte_idx_d  = byte_idx_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          byte_idx_d  = '0;
          out_valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          byte_idx_d  = byte_idx_q + IDX_W'(1);
          if (byte_idx_q == IDX_W'(BYTES - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        // A byte completing here overrides the handshake's clear above.
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q[2:0] == 3'd7) begin
            m1_d        = full1_c ^ mask_c;
            m2_d        = full2_c ^ mask_c;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      m1_q        <= '0;
      m2_q        <= '0;
      byte_idx_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      byte_idx_q  <= byte_idx_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign m1        = m1_q;
  assign m2        = m2_q;
  assign byte_idx  = byte_idx_q;
  assign done      = done_q;

  // Partial accumulator contents are internal only.
  logic unused_acc;
  assign unused_acc = ^{acc1, acc2};

endmodule

// File: tb/tb_polytomsg_masked_pack.sv
// Self-checking bench for polytomsg_masked_pack: table-driven whole-message
// vectors plus hand-written backpressure, simultaneous-event and reset
// sequences. Expected bytes go to a scoreboard queue when their 8th bit is
// accepted and are popped when the DUT hands the byte over.
module tb_polytomsg_masked_pack;

  localparam int unsigned N  = 256;
  localparam int unsigned NB = 32;
`ifdef POLYTOMSG_PACK_REFRESH_EN
  localparam logic [7:0] RND = 8'hA5;
`else
  localparam logic [7:0] RND = 8'h00;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x1;
  logic [15:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  m1;
  logic [7:0]  m2;
  logic [4:0]  byte_idx;
  logic        done;
  logic [7:0]  rnd;

  polytomsg_masked_pack dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m1        (m1),
    .m2        (m2),
    .byte_idx  (byte_idx),
    .done      (done)
`ifdef POLYTOMSG_PACK_REFRESH_EN
    ,
    .rnd       (rnd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] m1;
    logic [7:0] m2;
    logic [4:0] idx;
  } exp_t;

  typedef struct {
    logic [15:0] x1;
    logic [15:0] x2;
    logic [7:0]  em1;
    logic [7:0]  em2;
  } vec_t;

  int tests = 0;
  int fails = 0;
  exp_t sbq[$];
  exp_t e;
  logic [15:0] gx1[N];
  logic [15:0] gx2[N];
  logic [7:0]  e1[NB];
  logic [7:0]  e2[NB];
  int cyc = 0;
  int bytes_seen = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_hs_cyc = -10;
  bit msg_end;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on each byte handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got byte_idx %0d m1 %0h with empty scoreboard", byte_idx, m1);
        end else begin
          e = sbq.pop_front();
          check("byte_m1", 32'(m1), 32'(e.m1));
          check("byte_m2", 32'(m2), 32'(e.m2));
          check("byte_idx", 32'(byte_idx), 32'(e.idx));
          bytes_seen++;
          if (byte_idx == 5'd31) last_hs_cyc = cyc;
        end
      end
    end
  end

  task automatic fill_const(input logic [15:0] a, input logic [15:0] b,
                            input logic [7:0] em1, input logic [7:0] em2);
    for (int k = 0; k < N; k++) begin gx1[k] = a; gx2[k] = b; end
    for (int i = 0; i < NB; i++) begin e1[i] = em1; e2[i] = em2; end
  endtask

  // Random shares; expected bytes built from bit 12 of each share, LSB-first.
  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      gx1[k] = 16'($urandom);
      gx2[k] = 16'($urandom);
    end
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < 8; j++) begin
        e1[i][j] = gx1[i*8+j][12];
        e2[i][j] = gx2[i*8+j][12];
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_coeff(input int k);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    x1 = gx1[k];
    x2 = gx2[k];
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: coeff %0d never accepted", k);
    end else if (k % 8 == 7) begin
      sbq.push_back(exp_t'{e1[k/8] ^ RND, e2[k/8] ^ RND, 5'(k/8)});
    end
    in_valid = 1'b0;
  endtask

  task automatic run_msg(input string name);
    int d0;
    d0 = done_cnt;
    bytes_seen = 0;
    pulse_start();
    for (int k = 0; k < N; k++) send_coeff(k);
    for (int t = 0; t < 200 && done_cnt == d0; t++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    check({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({name, "_done_timing"}, 32'(done_cyc), 32'(last_hs_cyc + 1));
    check({name, "_bytes"}, 32'(bytes_seen), 32'(NB));
    check({name, "_sb_empty"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic check_reset(input string name);
    check({name, "_in_ready"}, 32'(in_ready), 32'd0);
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_m1"}, 32'(m1), 32'd0);
    check({name, "_m2"}, 32'(m2), 32'd0);
    check({name, "_byte_idx"}, 32'(byte_idx), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{16'h1000, 16'h0000, 8'hFF, 8'h00};
    vecs[1] = '{16'h0FFF, 16'h1000, 8'h00, 8'hFF};
    vecs[2] = '{16'hF000, 16'hFFFF, 8'hFF, 8'hFF};
    vecs[3] = '{16'hEFFF, 16'h3000, 8'h00, 8'hFF};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    x1 = '0; x2 = '0; out_ready = 1'b1; rnd = RND; msg_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Constant-pattern messages, including basic pack (0x1000 / 0x0000).
    for (int v = 0; v < 4; v++) begin
      fill_const(vecs[v].x1, vecs[v].x2, vecs[v].em1, vecs[v].em2);
      run_msg($sformatf("vec%0d", v));
    end

    // Bit order: only coefficients 0 and 9 carry a 1 in share 1.
    for (int k = 0; k < N; k++) begin
      gx1[k] = (k == 0 || k == 9) ? 16'h1000 : 16'hEFFF;
      gx2[k] = 16'h0000;
    end
    for (int i = 0; i < NB; i++) begin e1[i] = 8'h00; e2[i] = 8'h00; end
    e1[0] = 8'h01;
    e1[1] = 8'h02;
    run_msg("bitorder");

    // Backpressure after byte0, released into a simultaneous bit-7 / handshake.
    fill_random();
    fork
      run_msg("backpressure");
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 300 && !seen; t++) begin
          @(posedge clk); #1;
          seen = out_valid;
        end
        check("bp_byte0_seen", 32'(seen), 32'd1);
        out_ready = 1'b0;
        repeat (20) begin
          @(posedge clk); #1;
          check("bp_hold_m1", 32'(m1), 32'(e1[0] ^ RND));
          check("bp_hold_m2", 32'(m2), 32'(e2[0] ^ RND));
        end
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_idx", 32'(byte_idx), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("simul_out_valid", 32'(out_valid), 32'd1);
        check("simul_idx", 32'(byte_idx), 32'd1);
        check("simul_m1", 32'(m1), 32'(e1[1] ^ RND));
        check("simul_m2", 32'(m2), 32'(e2[1] ^ RND));
      end
    join

    // Random data with random downstream stalls.
    fill_random();
    msg_end = 1'b0;
    fork
      begin
        run_msg("random_stall");
        msg_end = 1'b1;
      end
      begin
        while (!msg_end) begin
          @(posedge clk); #1;
          if (!msg_end) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;

    // Reset mid-message, then a clean message from byte 0.
    fill_random();
    pulse_start();
    for (int k = 0; k < 100; k++) send_coeff(k);
    rst = 1'b1;
    #1;
    check_reset("midreset");
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_const(16'h1000, 16'h0000, 8'hFF, 8'h00);
    run_msg("after_reset");

`ifdef POLYTOMSG_PACK_REFRESH_EN
    // Refresh: one byte held and inspected, then aborted by reset.
    fill_const(16'h1000, 16'h0000, 8'hFF, 8'h00);
    out_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 8; k++) send_coeff(k);
    check("refresh_m1", 32'(m1), 32'h5A);
    check("refresh_m2", 32'(m2), 32'hA5);
    check("refresh_xor", 32'(m1 ^ m2), 32'hFF);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/polytomsg_masked_pack.md
# polytomsg_masked_pack

Final stage of the masked poly-to-message path: it consumes one pair of Boolean-masked coefficient shares per handshake and packs the message bit of each share into bytes. Message bits are packed LSB-first, 8 coefficients per byte, 256 coefficients per message. It emits 32 masked byte-share pairs (m1, m2) through a valid/ready port and pulses `done` after the last byte is taken. Shares are never combined inside the block.

## Interface
Parameters:
- KYBER_N, 256, coefficients per message; multiple of 8.
- COEFF_SZ, 16, width of each input share.
- QBITS2, 13, share modulus bits; message-bit share = bit QBITS2-1 of each input share.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a message; honoured only in IDLE.
- in_valid  in  1  coefficient share pair present.
- in_ready  out  1  block accepts the pair this cycle.
- x1  in  COEFF_SZ  Boolean share 1.
- x2  in  COEFF_SZ  Boolean share 2.
- out_valid  out  1  byte-share pair held.
- out_ready  in  1  downstream takes byte.
- m1  out  8  byte share 1.
- m2  out  8  byte share 2.
- byte_idx  out  $clog2(KYBER_N/8)  index of held byte.
- done  out  1  one-cycle pulse, message complete.

## Operation
- FSM states:
  - IDLE: start=1 -> RUN; clears coefficient counter, accumulators and byte_idx.
  - RUN: after the output handshake of the byte with byte_idx = KYBER_N/8-1 -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE unconditionally.
- Accept = in_valid && in_ready. On accept:
  - acc1[cnt[2:0]] <= x1[QBITS2-1] and acc2[cnt[2:0]] <= x2[QBITS2-1].
  - cnt increments.
- When cnt[2:0]=7 on accept, the completed bytes are loaded into m1/m2 and out_valid is set. The completed bytes include the current bit. Accumulators clear in the same cycle.
- in_ready = (state==RUN) && (cnt<KYBER_N) && (cnt[2:0]!=7 || !out_valid || out_ready).
  - Bits 0..6 of the next byte are accepted while the previous byte is stalled.
  - Bit 7 stalls until the output register frees.
- Simultaneous accept of bit 7 and output handshake: the new byte replaces the old one and out_valid stays 1.
- byte_idx increments on each output handshake; byte_idx is the index of the byte currently held.
- start outside IDLE is ignored. in_valid outside RUN is ignored, since in_ready=0.
- rst at any time returns everything to reset values; a partial message is discarded.
- Reset values: in_ready=0, out_valid=0, m1=0, m2=0, byte_idx=0, done=0, state=IDLE, cnt=0, accumulators=0.

## Timing
- Registered outputs except in_ready, which is combinational from state, cnt, out_valid and out_ready.
- Latency: byte visible on m1/m2 the cycle after its 8th bit is accepted.
- Throughput: 1 coefficient/cycle with out_ready=1; 256-coefficient message in 256 accept cycles.
- done asserts the cycle after the final output handshake.
- Earliest next start is the cycle after done.

## Configuration
- POLYTOMSG_PACK_REFRESH_EN defined:
  - Adds input port `rnd` (8 bits).
  - On byte load, m1 = acc1^rnd and m2 = acc2^rnd, re-masking each byte with fresh randomness.
  - m1^m2 is unchanged.
- Undefined: port absent; m1/m2 = raw accumulators.

## Structure
- Shared package holds:
  - KYBER_N and the KYBER_N/8 byte count constant.
  - The FSM state typedef (IDLE, RUN, DONE).
  - The message-bit index constant QBITS2-1.
- One sub-module: polytomsg_bit_accum.
  - 8-bit LSB-first shift/insert accumulator with load/clear.
  - Instantiated once per share so both shares have identical, independent datapaths.

## Test plan
- Basic pack:
  - Stimulus: reset, start, 256 pairs with x1=0x1000 and x2=0x0000 on every coefficient, out_ready=1.
  - Expect: 32 bytes with m1=0xFF, m2=0x00, byte_idx 0..31; done pulses once the cycle after byte 31.
- Bit order:
  - Stimulus: coefficient k has x1 bit 12 = (k==0 || k==9), x2 = 0.
  - Expect: byte0 m1=0x01, byte1 m1=0x02, all others 0x00.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after byte0.
  - Expect: in_ready drops at the 8th bit of byte1; byte0 stays stable on m1/m2; no bit is lost after release.
- Simultaneous events:
  - Stimulus: 8th-bit accept and output handshake in the same cycle.
  - Expect: out_valid stays 1, the next byte loads, byte_idx increments.
- Reset mid-message:
  - Stimulus: assert rst after 100 coefficients.
  - Expect: all outputs at reset values; a new start produces byte_idx from 0 and correct data.
- Refresh (macro on):
  - Stimulus: rnd=0xA5, x1 bit12=1, x2 bit12=0 for all coefficients.
  - Expect: m1=0x5A, m2=0xA5, m1^m2=0xFF.
